dram_sipo: RTL

DRAM_SIPO -- requirements
Module: dram_sipo

---
 rtl/dram_sipo_if.sv | 31 +++
 rtl/dram_sipo.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dram_sipo_if.sv
// Output word stream of the DRAM serial-to-parallel deserializer.
// Latency: none (wires only).
// Backpressure: valid/ready; master holds data_out/parity_err while out_valid && !out_ready.
//
// Signals:
//   data_out   - deserialized word (master -> slave)
//   out_valid  - data_out holds an unconsumed word (master -> slave)
//   parity_err - parity mismatch for the word, qualified by out_valid (master -> slave)
//   out_ready  - consumer accept (slave -> master)
interface dram_sipo_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             parity_err;
    logic             out_ready;

    modport master (
        output data_out,
        output out_valid,
        output parity_err,
        input  out_ready
    );

    modport slave (
        input  data_out,
        input  out_valid,
        input  parity_err,
        output out_ready
    );
endinterface

// File: rtl/dram_sipo.sv
// Serial-in parallel-out deserializer: collects a framed LSB-first bit stream into a WIDTH-bit word.
// Latency: word visible on out_if the cycle after its final bit is sampled (cycle WIDTH, or WIDTH+1 with parity).
// Backpressure: a word completing while a previous word is still unconsumed is dropped and overflow is set.
//
// Optional feature: define DRAM_SIPO_PARITY_EN to append one even-parity bit per frame
// and report mismatches on parity_err; otherwise parity_err is tied low.
//
// Ports:
//   clk, rst_b   - clock, asynchronous active-low reset
//   frame_start  - marks the cycle carrying bit 0 of a frame (restarts any frame in progress)
//   serial_in    - serial data bit, LSB first
//   clr_ovf      - clears the sticky overflow flag (a simultaneous set wins)
//   busy         - high while a frame is being collected
//   overflow     - sticky flag, a completed word was dropped
//   out_if       - output word stream (data_out, out_valid, parity_err, out_ready)
module dram_sipo #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         frame_start,
    input  logic         serial_in,
    input  logic         clr_ovf,
    output logic         busy,
    output logic         overflow,
    dram_sipo_if.master  out_if
);

    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef DRAM_SIPO_PARITY_EN
    // Parity bit sits at position WIDTH, after the last data bit.
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   word_nxt;
    logic               word_done;
    logic               load;
    logic               drop;

    logic [WIDTH-1:0]   data_q;
    logic               valid_q;
    logic               ovf_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state / shift datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        word_done = 1'b0;

        // Current bit dropped into position bit_cnt; when bit_cnt points at the
        // parity slot no data position matches and the word is unchanged.
        word_nxt = shreg_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt_q == CNT_W'(i)) begin
                word_nxt[i] = serial_in;
            end
        end

        if (frame_start) begin
            // New frame, or restart of one in progress (even on its final bit):
            // partial word discarded, this cycle's bit becomes bit 0.
            state_d   = SHIFT;
            bit_cnt_d = CNT_W'(1);
            shreg_d   = {{(WIDTH-1){1'b0}}, serial_in};
        end else if (state_q == SHIFT) begin
            if (bit_cnt_q == LAST_CNT) begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                word_done = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                shreg_d   = word_nxt;
            end
        end
    end

    // A finished word is accepted only if the output slot is empty or being
    // emptied on this same edge; otherwise it is lost.
    assign load = word_done && (!valid_q || out_if.out_ready);
    assign drop = word_done && valid_q && !out_if.out_ready;

    // ------------------------------------------------------------------
    // Output register and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (load) begin
                data_q  <= word_nxt;
                valid_q <= 1'b1;
            end else if (valid_q && out_if.out_ready) begin
                valid_q <= 1'b0;
            end

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef DRAM_SIPO_PARITY_EN
    logic perr_q;

    // Even parity over data plus parity bit: any odd total is a mismatch.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            perr_q <= 1'b0;
        end else if (load) begin
            perr_q <= ^{shreg_q, serial_in};
        end
    end

    assign out_if.parity_err = perr_q;
`else
    assign out_if.parity_err = 1'b0;
`endif

    assign out_if.data_out  = data_q;
    assign out_if.out_valid = valid_q;
    assign busy             = (state_q == SHIFT);
    assign overflow         = ovf_q;

endmodule
